// File: rtl/fll_cfg_regs.sv
// fll_cfg_regs: configuration register slave for one emulated FLL channel.
// Answers the 4-phase req/ack handshake from the APB FLL bridge, holds the
// CONFIG1/CONFIG2/INTEGRATOR registers and fakes a lock indication by counting
// HCLK cycles after every CONFIG1 write.
module fll_cfg_regs #(
    parameter logic [31:0] CFG1_RST    = 32'h0000_0100,
    parameter logic [31:0] CFG2_RST    = 32'h0000_0000,
    parameter int unsigned LOCK_CYCLES = 16
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        req_i,
    input  logic        wrn_i,
    input  logic [1:0]  add_i,
    input  logic [31:0] data_i,
    output logic        ack_o,
    output logic [31:0] r_data_o,
    output logic        lock_o,
    output logic [15:0] mult_factor_o,
    output logic [9:0]  dco_input_o,
    output logic [3:0]  clk_div_o,
    output logic        mode_o,
    output logic [31:0] cfg2_o,
    output logic [9:0]  integrator_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_t;

    localparam logic [1:0]  ADDR_STATUS = 2'd0;
    localparam logic [1:0]  ADDR_CFG1   = 2'd1;
    localparam logic [1:0]  ADDR_CFG2   = 2'd2;
    localparam logic [1:0]  ADDR_INTEG  = 2'd3;
    localparam logic [15:0] LOCK_LOAD   = 16'(LOCK_CYCLES);

    state_t      state_q, state_d;
    logic        req_meta, req_s;
    logic        ack_q, ack_d;
    logic [31:0] r_data_q;
    logic [31:0] cfg1_q;
    logic [31:0] cfg2_q;
    logic [9:0]  integ_q;
    logic [15:0] lock_cnt;
    logic        lock_q;

    logic        wr_en;
    logic        rd_en;
    logic        cfg1_wr;
    logic [31:0] rd_val;

    // Two-flop synchroniser for the request level coming from the bridge domain.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            req_meta <= 1'b0;
            req_s    <= 1'b0;
        end else begin
            req_meta <= req_i;
            req_s    <= req_meta;
        end
    end

    // Handshake state and ack flop; ack comes straight from a register.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
        end
    end

    // Next-state and ack: ACCESS always lasts one cycle, ACK waits for req to fall.
    always_comb begin
        state_d = state_q;
        ack_d   = ack_q;
        case (state_q)
            IDLE: begin
                ack_d = 1'b0;
                if (req_s) state_d = ACCESS;
            end
            ACCESS: begin
                ack_d   = 1'b1;
                state_d = ACK;
            end
            ACK: begin
                if (!req_s) begin
                    ack_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                ack_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // Access strobes; address/data are only looked at during ACCESS, when the
    // bridge guarantees they have been stable for two synchroniser cycles.
    always_comb begin
        wr_en   = (state_q == ACCESS) && !wrn_i;
        rd_en   = (state_q == ACCESS) && wrn_i;
        cfg1_wr = wr_en && (add_i == ADDR_CFG1);
    end

    // Read mux; STATUS reflects lock and multiplier as registered before this edge.
    always_comb begin
        rd_val = 32'h0;
        case (add_i)
            ADDR_STATUS: rd_val = {15'b0, lock_q, cfg1_q[15:0]};
            ADDR_CFG1:   rd_val = cfg1_q;
            ADDR_CFG2:   rd_val = cfg2_q;
            ADDR_INTEG:  rd_val = {6'b0, integ_q, 16'b0};
            default:     rd_val = 32'h0;
        endcase
    end

    // Register file writes; STATUS writes are accepted but dropped.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            cfg1_q  <= CFG1_RST;
            cfg2_q  <= CFG2_RST;
            integ_q <= 10'h0;
        end else if (wr_en) begin
            case (add_i)
                ADDR_CFG1:  cfg1_q  <= data_i;
                ADDR_CFG2:  cfg2_q  <= data_i;
                ADDR_INTEG: integ_q <= data_i[25:16];
                default:    ;
            endcase
        end
    end

    // Read data holds its value except when a read completes.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_data_q <= 32'h0;
        end else if (rd_en) begin
            r_data_q <= rd_val;
        end
    end

    // Lock emulation: reload on every CONFIG1 write (reload beats expiry),
    // otherwise count down to zero and raise lock on the 1 -> 0 step.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            lock_cnt <= LOCK_LOAD;
            lock_q   <= 1'b0;
        end else if (cfg1_wr) begin
            lock_cnt <= LOCK_LOAD;
            lock_q   <= 1'b0;
        end else if (lock_cnt != 16'h0) begin
            lock_cnt <= lock_cnt - 16'h1;
            if (lock_cnt == 16'h1) lock_q <= 1'b1;
        end
    end

    assign ack_o         = ack_q;
    assign r_data_o      = r_data_q;
    assign lock_o        = lock_q;
    assign mult_factor_o = cfg1_q[15:0];
    assign dco_input_o   = cfg1_q[25:16];
    assign clk_div_o     = cfg1_q[29:26];
    assign mode_o        = cfg1_q[31];
    assign cfg2_o        = cfg2_q;
    assign integrator_o  = integ_q;

endmodule

// File: tb/tb_fll_cfg_regs.sv
// tb_fll_cfg_regs: directed checks of the FLL config register slave.
module tb_fll_cfg_regs;

    logic        HCLK;
    logic        HRESETn;
    logic        req_i;
    logic        wrn_i;
    logic [1:0]  add_i;
    logic [31:0] data_i;
    logic        ack_o;
    logic [31:0] r_data_o;
    logic        lock_o;
    logic [15:0] mult_factor_o;
    logic [9:0]  dco_input_o;
    logic [3:0]  clk_div_o;
    logic        mode_o;
    logic [31:0] cfg2_o;
    logic [9:0]  integrator_o;

    int total = 0;
    int bad   = 0;

    fll_cfg_regs dut (
        .HCLK          (HCLK),
        .HRESETn       (HRESETn),
        .req_i         (req_i),
        .wrn_i         (wrn_i),
        .add_i         (add_i),
        .data_i        (data_i),
        .ack_o         (ack_o),
        .r_data_o      (r_data_o),
        .lock_o        (lock_o),
        .mult_factor_o (mult_factor_o),
        .dco_input_o   (dco_input_o),
        .clk_div_o     (clk_div_o),
        .mode_o        (mode_o),
        .cfg2_o        (cfg2_o),
        .integrator_o  (integrator_o)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // Step one edge and settle; inputs changed here are sampled on the next edge.
    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    // Raise req and wait for ack; lat = edges after the first sampling edge.
    task automatic start_access(input logic wrn, input logic [1:0] add,
                                input logic [31:0] data, output int lat);
        int n;
        n      = 0;
        wrn_i  = wrn;
        add_i  = add;
        data_i = data;
        req_i  = 1'b1;
        while (n < 20) begin
            tick();
            n++;
            if (ack_o === 1'b1) break;
        end
        if (ack_o !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL ack_rise_timeout: ack=%b required 1", ack_o);
        end
        lat = n - 1;
    endtask

    // Drop req and wait for ack to fall.
    task automatic end_access(output int lat);
        int n;
        n     = 0;
        req_i = 1'b0;
        while (n < 20) begin
            tick();
            n++;
            if (ack_o === 1'b0) break;
        end
        if (ack_o !== 1'b0) begin
            total++;
            bad++;
            $display("FAIL ack_fall_timeout: ack=%b required 0", ack_o);
        end
        lat = n - 1;
        tick();
    endtask

    task automatic test_reset();
        logic early;
        HRESETn = 1'b0;
        req_i = 1'b0; wrn_i = 1'b1; add_i = 2'd0; data_i = 32'h0;
        repeat (3) tick();
        HRESETn = 1'b1;
        total++;
        if (ack_o !== 1'b0) begin bad++; $display("FAIL rst_ack: got %b want 0", ack_o); end
        total++;
        if (mult_factor_o !== 16'h0100) begin bad++; $display("FAIL rst_mult: got %h want 0100", mult_factor_o); end
        total++;
        if (lock_o !== 1'b0) begin bad++; $display("FAIL rst_lock: got %b want 0", lock_o); end
        total++;
        if (cfg2_o !== 32'h0 || integrator_o !== 10'h0 || r_data_o !== 32'h0) begin
            bad++; $display("FAIL rst_regs: cfg2=%h integ=%h rdata=%h want 0", cfg2_o, integrator_o, r_data_o);
        end
        early = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (lock_o !== 1'b0) early = 1'b1;
        end
        total++;
        if (early) begin bad++; $display("FAIL rst_lock_early: lock rose before 16 edges"); end
        tick();
        total++;
        if (lock_o !== 1'b1) begin bad++; $display("FAIL rst_lock_16: got %b want 1", lock_o); end
    endtask

    task automatic test_cfg2();
        int lat;
        start_access(1'b0, 2'd2, 32'hDEAD_BEEF, lat);
        total++;
        if (lat != 3) begin bad++; $display("FAIL wr_latency: got %0d want 3", lat); end
        total++;
        if (r_data_o !== 32'h0) begin bad++; $display("FAIL wr_rdata_held: got %h want 0", r_data_o); end
        end_access(lat);
        total++;
        if (lat != 2) begin bad++; $display("FAIL release_latency: got %0d want 2", lat); end
        total++;
        if (cfg2_o !== 32'hDEAD_BEEF) begin bad++; $display("FAIL cfg2_out: got %h want deadbeef", cfg2_o); end
        start_access(1'b1, 2'd2, 32'h0, lat);
        total++;
        if (r_data_o !== 32'hDEAD_BEEF) begin bad++; $display("FAIL cfg2_read: got %h want deadbeef", r_data_o); end
        total++;
        if (lat != 3) begin bad++; $display("FAIL rd_latency: got %0d want 3", lat); end
        end_access(lat);
    endtask

    task automatic test_lock();
        int lat;
        logic early;
        start_access(1'b0, 2'd1, 32'h8C3F_05F5, lat);
        // ack just rose on the ACCESS edge
        total++;
        if (lock_o !== 1'b0) begin bad++; $display("FAIL relock_clear: got %b want 0", lock_o); end
        total++;
        if (mode_o !== 1'b1 || clk_div_o !== 4'h3 || dco_input_o !== 10'h03F || mult_factor_o !== 16'h05F5) begin
            bad++;
            $display("FAIL cfg1_fields: mode=%b div=%h dco=%h mult=%h want 1/3/03f/05f5",
                     mode_o, clk_div_o, dco_input_o, mult_factor_o);
        end
        early = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (lock_o !== 1'b0) early = 1'b1;
        end
        total++;
        if (early) begin bad++; $display("FAIL relock_early: lock rose before 16 edges"); end
        tick();
        total++;
        if (lock_o !== 1'b1) begin bad++; $display("FAIL relock_16: got %b want 1", lock_o); end
        end_access(lat);
        start_access(1'b1, 2'd1, 32'h0, lat);
        total++;
        if (r_data_o !== 32'h8C3F_05F5) begin bad++; $display("FAIL cfg1_read: got %h want 8c3f05f5", r_data_o); end
        end_access(lat);
        start_access(1'b1, 2'd0, 32'h0, lat);
        total++;
        if (r_data_o !== 32'h0001_05F5) begin bad++; $display("FAIL status_read: got %h want 000105f5", r_data_o); end
        end_access(lat);
    endtask

    task automatic test_masked();
        int lat;
        start_access(1'b0, 2'd3, 32'hFFFF_FFFF, lat);
        end_access(lat);
        total++;
        if (integrator_o !== 10'h3FF) begin bad++; $display("FAIL integ_out: got %h want 3ff", integrator_o); end
        start_access(1'b1, 2'd3, 32'h0, lat);
        total++;
        if (r_data_o !== 32'h03FF_0000) begin bad++; $display("FAIL integ_read: got %h want 03ff0000", r_data_o); end
        end_access(lat);
        // STATUS write: acknowledged, nothing moves
        start_access(1'b0, 2'd0, 32'h1234_5678, lat);
        total++;
        if (lat != 3) begin bad++; $display("FAIL status_wr_ack: latency %0d want 3", lat); end
        end_access(lat);
        total++;
        if (mult_factor_o !== 16'h05F5 || dco_input_o !== 10'h03F || clk_div_o !== 4'h3 || mode_o !== 1'b1 ||
            cfg2_o !== 32'hDEAD_BEEF || integrator_o !== 10'h3FF || lock_o !== 1'b1 || r_data_o !== 32'h03FF_0000) begin
            bad++;
            $display("FAIL status_wr_noeffect: mult=%h dco=%h div=%h mode=%b cfg2=%h integ=%h lock=%b rdata=%h",
                     mult_factor_o, dco_input_o, clk_div_o, mode_o, cfg2_o, integrator_o, lock_o, r_data_o);
        end
    endtask

    task automatic test_write_during_count();
        int lat;
        logic early;
        early = 1'b0;
        start_access(1'b0, 2'd1, 32'h0000_0200, lat);
        if (lock_o !== 1'b0) early = 1'b1;
        end_access(lat);
        if (lock_o !== 1'b0) early = 1'b1;
        start_access(1'b0, 2'd1, 32'h0000_0300, lat);
        if (lock_o !== 1'b0) early = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (lock_o !== 1'b0) early = 1'b1;
        end
        total++;
        if (early) begin bad++; $display("FAIL wdc_lock_low: lock rose before 16 edges after second write"); end
        tick();
        total++;
        if (lock_o !== 1'b1) begin bad++; $display("FAIL wdc_lock_16: got %b want 1", lock_o); end
        end_access(lat);
        total++;
        if (mult_factor_o !== 16'h0300) begin bad++; $display("FAIL wdc_mult: got %h want 0300", mult_factor_o); end
    endtask

    task automatic test_reset_mid();
        int lat;
        start_access(1'b0, 2'd2, 32'h5555_AAAA, lat);
        // now in ACK with req held high
        #2;
        HRESETn = 1'b0;
        #1;
        total++;
        if (ack_o !== 1'b0) begin bad++; $display("FAIL midrst_ack: got %b want 0", ack_o); end
        total++;
        if (mult_factor_o !== 16'h0100 || cfg2_o !== 32'h0 || integrator_o !== 10'h0 ||
            lock_o !== 1'b0 || r_data_o !== 32'h0 || mode_o !== 1'b0) begin
            bad++;
            $display("FAIL midrst_regs: mult=%h cfg2=%h integ=%h lock=%b rdata=%h mode=%b",
                     mult_factor_o, cfg2_o, integrator_o, lock_o, r_data_o, mode_o);
        end
        tick();
        HRESETn = 1'b1;
        // req still high with a CONFIG2 read set up; first edge after release samples it
        wrn_i = 1'b1;
        start_access(1'b1, 2'd2, 32'h0, lat);
        total++;
        if (lat != 3) begin bad++; $display("FAIL midrst_relaunch: latency %0d want 3", lat); end
        total++;
        if (r_data_o !== 32'h0) begin bad++; $display("FAIL midrst_read: got %h want 0", r_data_o); end
        end_access(lat);
    endtask

    initial begin
        test_reset();
        test_cfg2();
        test_lock();
        test_masked();
        test_write_during_count();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
